// File: rtl/vdp_vram_port.sv
// CPU-side VRAM access port: control-port byte phase, auto-incrementing VRAM address,
// data-port reads/writes with a 1-byte read-ahead buffer, single-byte req/ack to the arbiter.
module vdp_vram_port #(
  parameter int ADDR_W = 14
) (
  input  logic              pxclk,
  input  logic              reset,
  input  logic              wr_tick,
  input  logic              rd_tick,
  input  logic              mode,
  input  logic [7:0]        din,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              overrun,
  output logic              vram_req,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  input  logic              vram_ack,
  input  logic [7:0]        vram_rdata
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state_reg;
  logic              phase_reg;
  logic [7:0]        lo_reg;
  logic [ADDR_W-1:0] addr_reg;

  logic              rd_eff;
  logic              ctrl_wr;
  logic              data_wr;
  logic              data_rd;
  logic [13:0]       setup_full;
  logic [ADDR_W-1:0] addr_cur;
  logic              launch;
  logic              launch_we;
  logic              in_flight;
  logic              phase_next;

  // A write strobe masks a coincident read strobe.
  assign rd_eff    = rd_tick & ~wr_tick;
  assign ctrl_wr   = wr_tick & mode;
  assign data_wr   = wr_tick & ~mode;
  assign data_rd   = rd_eff & ~mode;
  assign in_flight = (state_reg == REQ);
  assign setup_full = {din[5:0], lo_reg};

  always_comb begin
    addr_cur   = addr_reg;
    launch     = 1'b0;
    launch_we  = 1'b0;
    phase_next = phase_reg;
    if (ctrl_wr) begin
      phase_next = ~phase_reg;
      // Second control byte without bit 7 is an address setup; bit 6 clear means read setup.
      if (phase_reg && !din[7]) begin
        addr_cur = ADDR_W'(setup_full);
        launch   = ~din[6];
      end
    end else if (wr_tick || rd_tick) begin
      phase_next = 1'b0;
    end
    if (data_wr) begin
      launch    = 1'b1;
      launch_we = 1'b1;
    end
    if (data_rd) begin
      launch = 1'b1;
    end
  end

  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      phase_reg  <= 1'b0;
      lo_reg     <= 8'h00;
      addr_reg   <= '0;
      rd_data    <= 8'h00;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      vram_req   <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= 8'h00;
    end else begin
      overrun   <= 1'b0;
      phase_reg <= phase_next;
      if (ctrl_wr && !phase_reg) begin
        lo_reg <= din;
      end

      // The ack cycle still counts as busy, so launches are only accepted from IDLE.
      if (launch && !in_flight) begin
        vram_addr <= addr_cur;
        addr_reg  <= addr_cur + ADDR_W'(1);
        vram_we   <= launch_we;
        if (launch_we) begin
          vram_wdata <= din;
          rd_data    <= din;
        end
        vram_req  <= 1'b1;
        busy      <= 1'b1;
        state_reg <= REQ;
      end else begin
        addr_reg <= addr_cur;
        if (launch) begin
          overrun <= 1'b1;
        end
      end

      if (in_flight && vram_ack) begin
        state_reg <= IDLE;
        vram_req  <= 1'b0;
        busy      <= 1'b0;
        if (!vram_we) begin
          rd_data <= vram_rdata;
        end
      end
    end
  end

endmodule
